// File: rtl/data_mem_stage_pkg.sv
// Shared types and helpers for the MIPS MEM stage: access-type codes,
// lane enables, store replication, load extension and the MEM/WB bundle.
package mem_stage_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_e;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] pc_to_reg;
        logic [4:0]  addr_reg_dst;
        logic        reg_write;
        logic        mem_to_reg;
        logic        write_pc;
        logic        misaligned;
    } mem_wb_t;

    // Loads and stores agree on access size through the low two type bits.
    function automatic size_e ls_size(input logic [1:0] t);
        case (t)
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic ls_misaligned(input logic [1:0] t,
                                           input logic [1:0] off);
        case (ls_size(t))
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] ls_byte_en(input logic [1:0] t,
                                              input logic [1:0] off);
        case (ls_size(t))
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] ls_store_data(input logic [1:0]  t,
                                                  input logic [31:0] rt);
        case (ls_size(t))
            SZ_B:    return {4{rt[7:0]}};
            SZ_H:    return {2{rt[15:0]}};
            default: return rt;
        endcase
    endfunction

    function automatic logic [31:0] ls_extend(input logic [2:0]  t,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (t)
            LS_B:    return {{24{b[7]}}, b};
            LS_BU:   return {24'd0, b};
            LS_H:    return {{16{h[15]}}, h};
            LS_HU:   return {16'd0, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_stage_ram.sv
// Byte-enable synchronous data RAM, read-first, one-cycle read latency.
// DATA_MEM_DEBUG_PORT_EN adds an always-active second read port.
module data_ram
    import mem_stage_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    input  logic              i_re,
    output logic [31:0]       o_rdata
`ifdef DATA_MEM_DEBUG_PORT_EN
    ,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [31:0]       o_dbg_data
`endif
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (rst)
            rdata_d = '0;
        else if (i_re)
            rdata_d = mem_q[i_addr];
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i])
                    mem_q[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
            end
        end
    end

    assign o_rdata = rdata_q;

`ifdef DATA_MEM_DEBUG_PORT_EN
    logic [31:0] dbg_q, dbg_d;

    always_comb begin
        dbg_d = rst ? '0 : mem_q[i_dbg_addr];
    end

    always_ff @(posedge clk) begin
        dbg_q <= dbg_d;
    end

    assign o_dbg_data = dbg_q;
`endif

endmodule

// File: rtl/data_mem_stage.sv
// MEM stage: load/store lane alignment, misalignment checks, MEM/WB registers.
// Optional debug read port enabled by DATA_MEM_DEBUG_PORT_EN.
module data_mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_enable,
    input  logic [DATA_W-1:0] i_ALU_res,
    input  logic [DATA_W-1:0] i_rt_reg,
    input  logic [DATA_W-1:0] i_pc_to_reg,
    input  logic [4:0]        i_addr_reg_dst,
    input  logic              is_RegWrite,
    input  logic              is_MemtoReg,
    input  logic              is_MemWrite,
    input  logic              is_MemRead,
    input  logic              is_write_pc,
    input  logic [2:0]        is_load_store_type,
    output logic [DATA_W-1:0] o_read_data,
    output logic [DATA_W-1:0] o_ALU_res,
    output logic [DATA_W-1:0] o_pc_to_reg,
    output logic [4:0]        o_addr_reg_dst,
    output logic              os_RegWrite,
    output logic              os_MemtoReg,
    output logic              os_write_pc,
    output logic              os_misaligned
`ifdef DATA_MEM_DEBUG_PORT_EN
    ,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [31:0]       o_dbg_data
`endif
);

    logic [1:0]        off;
    logic [ADDR_W-1:0] widx;
    logic              mis;
    logic              ram_we;
    logic              ram_re;
    logic [31:0]       ram_rdata;

    mem_wb_t     wb_q, wb_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  typ_q, typ_d;

    assign off  = i_ALU_res[1:0];
    assign widx = i_ALU_res[ADDR_W+1:2];
    assign mis  = ls_misaligned(is_load_store_type[1:0], off);

    assign ram_we = i_enable && is_MemWrite && !mis && !rst;
    assign ram_re = i_enable && is_MemRead;

    data_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (ram_we),
        .i_be    (ls_byte_en(is_load_store_type[1:0], off)),
        .i_addr  (widx),
        .i_wdata (ls_store_data(is_load_store_type[1:0], i_rt_reg)),
        .i_re    (ram_re),
        .o_rdata (ram_rdata)
`ifdef DATA_MEM_DEBUG_PORT_EN
        ,
        .i_dbg_addr (i_dbg_addr),
        .o_dbg_data (o_dbg_data)
`endif
    );

    always_comb begin
        wb_d  = wb_q;
        off_d = off_q;
        typ_d = typ_q;
        if (rst) begin
            wb_d  = '0;
            off_d = '0;
            typ_d = '0;
        end else if (i_enable) begin
            wb_d.alu_res      = i_ALU_res;
            wb_d.pc_to_reg    = i_pc_to_reg;
            wb_d.addr_reg_dst = i_addr_reg_dst;
            wb_d.reg_write    = is_RegWrite && !(is_MemRead && mis);
            wb_d.mem_to_reg   = is_MemtoReg;
            wb_d.write_pc     = is_write_pc;
            wb_d.misaligned   = (is_MemRead || is_MemWrite) && mis;
            // Extension state follows the RAM output register.
            if (is_MemRead) begin
                off_d = off;
                typ_d = is_load_store_type;
            end
        end
    end

    always_ff @(posedge clk) begin
        wb_q  <= wb_d;
        off_q <= off_d;
        typ_q <= typ_d;
    end

    assign o_read_data    = ls_extend(typ_q, off_q, ram_rdata);
    assign o_ALU_res      = wb_q.alu_res;
    assign o_pc_to_reg    = wb_q.pc_to_reg;
    assign o_addr_reg_dst = wb_q.addr_reg_dst;
    assign os_RegWrite    = wb_q.reg_write;
    assign os_MemtoReg    = wb_q.mem_to_reg;
    assign os_write_pc    = wb_q.write_pc;
    assign os_misaligned  = wb_q.misaligned;

endmodule

// File: tb/tb_data_mem_stage.sv
// Scoreboard bench for data_mem_stage: byte-array memory model,
// directed test-plan sequence followed by randomized traffic.
module tb_data_mem_stage;

    localparam logic [2:0] T_B  = 3'b000;
    localparam logic [2:0] T_H  = 3'b001;
    localparam logic [2:0] T_W  = 3'b010;
    localparam logic [2:0] T_BU = 3'b100;
    localparam logic [2:0] T_HU = 3'b101;

    typedef struct packed {
        logic        rst;
        logic        en;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [31:0] pc;
        logic [4:0]  dst;
        logic        rw;
        logic        m2r;
        logic        mw;
        logic        mr;
        logic        wpc;
        logic [2:0]  typ;
    } instr_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] pc;
        logic [4:0]  dst;
        logic        rw;
        logic        m2r;
        logic        wpc;
        logic        mis;
        logic [31:0] rd;
        logic        rd_known;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable;
    logic [31:0] i_ALU_res, i_rt_reg, i_pc_to_reg;
    logic [4:0]  i_addr_reg_dst;
    logic        is_RegWrite, is_MemtoReg, is_MemWrite, is_MemRead;
    logic        is_write_pc;
    logic [2:0]  is_load_store_type;
    logic [31:0] o_read_data, o_ALU_res, o_pc_to_reg;
    logic [4:0]  o_addr_reg_dst;
    logic        os_RegWrite, os_MemtoReg, os_write_pc, os_misaligned;

    data_mem_stage dut (
        .clk                (clk),
        .rst                (rst),
        .i_enable           (i_enable),
        .i_ALU_res          (i_ALU_res),
        .i_rt_reg           (i_rt_reg),
        .i_pc_to_reg        (i_pc_to_reg),
        .i_addr_reg_dst     (i_addr_reg_dst),
        .is_RegWrite        (is_RegWrite),
        .is_MemtoReg        (is_MemtoReg),
        .is_MemWrite        (is_MemWrite),
        .is_MemRead         (is_MemRead),
        .is_write_pc        (is_write_pc),
        .is_load_store_type (is_load_store_type),
        .o_read_data        (o_read_data),
        .o_ALU_res          (o_ALU_res),
        .o_pc_to_reg        (o_pc_to_reg),
        .o_addr_reg_dst     (o_addr_reg_dst),
        .os_RegWrite        (os_RegWrite),
        .os_MemtoReg        (os_MemtoReg),
        .os_write_pc        (os_write_pc),
        .os_misaligned      (os_misaligned)
    );

    always #5 clk = ~clk;

    logic [7:0]  mb [1024];
    exp_t        sb [$];
    exp_t        last;
    logic [31:0] cur_rd;
    logic        rd_known;
    int          n_tot = 0;
    int          n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_tot++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s at %0t: got %h required %h", nm, $time, act, req);
    endtask

    function automatic instr_t mk(input logic r, input logic en,
                                  input logic [31:0] alu, input logic [31:0] rt,
                                  input logic mr, input logic mw,
                                  input logic [2:0] typ);
        instr_t x;
        x.rst = r;
        x.en  = en;
        x.alu = alu;
        x.rt  = rt;
        x.pc  = alu + 32'd4;
        x.dst = alu[6:2];
        x.rw  = !mw;
        x.m2r = mr;
        x.mw  = mw;
        x.mr  = mr;
        x.wpc = alu[0];
        x.typ = typ;
        return x;
    endfunction

    // Reference: byte-addressed little-endian memory, reads before writes.
    task automatic send(input instr_t x);
        exp_t        e;
        int          a, off, sz;
        logic        sgn, mis;
        logic [31:0] v;
        @(negedge clk);
        rst                = x.rst;
        i_enable           = x.en;
        i_ALU_res          = x.alu;
        i_rt_reg           = x.rt;
        i_pc_to_reg        = x.pc;
        i_addr_reg_dst     = x.dst;
        is_RegWrite        = x.rw;
        is_MemtoReg        = x.m2r;
        is_MemWrite        = x.mw;
        is_MemRead         = x.mr;
        is_write_pc        = x.wpc;
        is_load_store_type = x.typ;
        if (x.rst) begin
            cur_rd   = 0;
            rd_known = 1'b1;
        end else if (x.en) begin
            a   = int'(x.alu % 1024);
            off = a % 4;
            sz  = (x.typ % 4 == 0) ? 1 : (x.typ % 4 == 1) ? 2 : 4;
            sgn = (x.typ == T_B) || (x.typ == T_H);
            mis = (sz == 2 && off % 2 != 0) || (sz == 4 && off != 0);
            if (x.mr) begin
                if (mis) begin
                    rd_known = 1'b0;
                end else begin
                    v = 0;
                    for (int i = 0; i < sz; i++)
                        v = v | (32'(mb[a+i]) << (8 * i));
                    if (sgn && sz == 1 && v[7])
                        v = v | 32'hFFFFFF00;
                    if (sgn && sz == 2 && v[15])
                        v = v | 32'hFFFF0000;
                    cur_rd   = v;
                    rd_known = 1'b1;
                end
            end
            if (x.mw && !mis) begin
                for (int i = 0; i < sz; i++)
                    mb[a+i] = 8'((x.rt >> (8 * i)) & 32'hFF);
            end
            e.alu      = x.alu;
            e.pc       = x.pc;
            e.dst      = x.dst;
            e.rw       = x.rw && !(x.mr && mis);
            e.m2r      = x.m2r;
            e.wpc      = x.wpc;
            e.mis      = (x.mr || x.mw) && mis;
            e.rd       = cur_rd;
            e.rd_known = rd_known;
            sb.push_back(e);
        end
    endtask

    always @(posedge clk) begin : monitor
        logic fire, was_rst;
        exp_t e;
        fire    = i_enable && !rst;
        was_rst = rst;
        #1;
        if (was_rst) begin
            e          = '0;
            e.rd_known = 1'b1;
        end else if (fire) begin
            if (sb.size() == 0) begin
                n_tot++;
                $display("FAIL sb_underflow at %0t: got empty queue required entry",
                         $time);
                e = last;
            end else begin
                e = sb.pop_front();
            end
        end else begin
            e = last;
        end
        chk("alu_res", o_ALU_res, e.alu);
        chk("pc_to_reg", o_pc_to_reg, e.pc);
        chk("reg_dst", 32'(o_addr_reg_dst), 32'(e.dst));
        chk("ctrl", {28'd0, os_RegWrite, os_MemtoReg, os_write_pc, os_misaligned},
            {28'd0, e.rw, e.m2r, e.wpc, e.mis});
        if (e.rd_known)
            chk("read_data", o_read_data, e.rd);
        last = e;
    end

    initial begin
        instr_t x;
        logic [31:0] r;
        cur_rd   = 0;
        rd_known = 1'b1;
        last     = '0;
        rst = 1'b1; i_enable = 1'b0; i_ALU_res = '0; i_rt_reg = '0;
        i_pc_to_reg = '0; i_addr_reg_dst = '0; is_RegWrite = 1'b0;
        is_MemtoReg = 1'b0; is_MemWrite = 1'b0; is_MemRead = 1'b0;
        is_write_pc = 1'b0; is_load_store_type = '0;
        send(mk(1, 1, 0, 0, 0, 0, T_W));
        send(mk(1, 0, 0, 0, 0, 0, T_W));
        for (int w = 0; w < 64; w++)
            send(mk(0, 1, 32'(w * 4), 0, 0, 1, T_W));

        send(mk(0, 1, 32'h10, 32'hDEADBEEF, 0, 1, T_W));
        send(mk(0, 1, 32'h10, 0, 1, 0, T_W));
        send(mk(0, 1, 32'h10, 0, 0, 1, T_W));
        send(mk(0, 1, 32'h13, 32'h80, 0, 1, T_B));
        send(mk(0, 1, 32'h13, 0, 1, 0, T_B));
        send(mk(0, 1, 32'h13, 0, 1, 0, T_BU));
        send(mk(0, 1, 32'h10, 0, 1, 0, T_W));
        send(mk(0, 1, 32'h22, 32'h8001, 0, 1, T_H));
        send(mk(0, 1, 32'h22, 0, 1, 0, T_H));
        send(mk(0, 1, 32'h22, 0, 1, 0, T_HU));
        send(mk(0, 1, 32'h21, 0, 1, 0, T_H));
        send(mk(0, 1, 32'h04, 32'h0BADF00D, 0, 1, T_W));
        send(mk(0, 1, 32'h05, 32'h12345678, 0, 1, T_W));
        send(mk(0, 1, 32'h04, 0, 1, 0, T_W));
        send(mk(0, 1, 32'h10, 0, 1, 0, T_W));
        for (int i = 0; i < 3; i++)
            send(mk(0, 0, 32'h10, 32'hFFFFFFFF, 0, 1, T_W));
        send(mk(0, 1, 32'h10, 0, 1, 0, T_W));
        send(mk(0, 1, 32'h30, 32'h5555AAAA, 0, 1, T_W));
        send(mk(1, 1, 32'h30, 32'h1234, 0, 1, T_W));
        send(mk(0, 1, 32'h30, 0, 1, 0, T_W));
        send(mk(0, 1, 32'h10, 0, 1, 0, T_W));
        send(mk(0, 1, 32'h430, 0, 1, 0, T_W));
        send(mk(0, 1, 32'h40, 32'hCAFE0001, 1, 1, T_W));
        send(mk(0, 1, 32'h40, 0, 1, 0, T_W));

        for (int n = 0; n < 600; n++) begin
            x.rst = ($urandom_range(0, 49) == 0);
            x.en  = ($urandom_range(0, 9) != 0);
            r     = $urandom();
            x.alu = 32'($urandom_range(0, 255));
            if (r[0])
                x.alu = x.alu | (r & 32'hFFFFFC00);
            x.rt  = $urandom();
            x.pc  = $urandom();
            x.dst = 5'($urandom_range(0, 31));
            x.rw  = 1'($urandom_range(0, 1));
            x.m2r = 1'($urandom_range(0, 1));
            x.mw  = 1'($urandom_range(0, 1));
            x.mr  = 1'($urandom_range(0, 1));
            x.wpc = 1'($urandom_range(0, 1));
            x.typ = 3'($urandom_range(0, 7));
            send(x);
        end

        for (int i = 0; i < 3; i++)
            send(mk(0, 0, 0, 0, 0, 0, T_W));
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
